// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers a 4-bit PWM duty level from a sampled waveform.
// Ports: clk, rst (async high), pwm_in (async) -> duty, duty_valid, period_err, full_on, locked.
module pwm_duty_decoder #(
  parameter int unsigned PERIOD = 16,
  parameter int unsigned TOL    = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [3:0] duty,
  output logic       duty_valid,
  output logic       period_err,
  output logic       full_on,
  output logic       locked
);

  typedef enum logic [1:0] {
    SEEK,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0] IDLE_PRE = CNT_W'(2 * PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_SAT = CNT_W'(15);
  localparam int unsigned PER_LO = (PERIOD > TOL) ? PERIOD - TOL : 0;
  localparam int unsigned PER_HI = PERIOD + TOL;

  // Reset asserts at once, releases two clocks later.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic             sync1_q;
  logic             pwm_s_q;
  logic             pwm_d_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]       duty_q, duty_d;
  logic             duty_valid_q, duty_valid_d;
  logic             period_err_q, period_err_d;
  logic             full_on_q, full_on_d;
  logic             locked_q, locked_d;

  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             timeout;
  logic             per_ok;
  logic [31:0]      per_ext;
  logic [CNT_W-1:0] hi_inc;
  logic [CNT_W-1:0] per_inc;
  logic [3:0]       hi_duty;

  assign rise     = pwm_s_q & ~pwm_d_q;
  assign fall     = ~pwm_s_q & pwm_d_q;
  assign any_edge = rise | fall;
  // Fires once on the cycle idle_cnt reaches its ceiling; an edge wins.
  assign timeout  = ~any_edge & (idle_cnt_q == IDLE_PRE);
  assign per_ext  = 32'(per_cnt_q);
  assign per_ok   = (per_ext >= PER_LO) & (per_ext <= PER_HI);
  assign hi_inc   = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_ONE;
  assign per_inc  = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
  assign hi_duty  = (hi_cnt_q >= DUTY_SAT) ? 4'd15 : hi_cnt_q[3:0];

  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    per_cnt_d    = per_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    period_err_d = 1'b0;
    full_on_d    = full_on_q;
    locked_d     = locked_q;

    if (any_edge) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + CNT_ONE;
    end

    unique case (state_q)
      SEEK: begin
        if (rise) begin
          state_d   = HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d   = LOW;
          per_cnt_d = per_inc;
        end else if (pwm_s_q) begin
          hi_cnt_d  = hi_inc;
          per_cnt_d = per_inc;
        end
      end
      LOW: begin
        if (rise) begin
          if (per_ok) begin
            duty_d       = hi_duty;
            duty_valid_d = 1'b1;
            locked_d     = 1'b1;
            full_on_d    = 1'b0;
          end else begin
            period_err_d = 1'b1;
            locked_d     = 1'b0;
          end
          state_d   = HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      default: begin
        state_d = SEEK;
      end
    endcase

    // Timeout excludes an edge, so no period closed this cycle.
    if (timeout) begin
      duty_d       = pwm_s_q ? 4'd15 : 4'd0;
      full_on_d    = pwm_s_q;
      duty_valid_d = 1'b1;
      locked_d     = 1'b1;
      state_d      = SEEK;
    end
  end

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      sync1_q      <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_d_q      <= 1'b0;
      state_q      <= SEEK;
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      full_on_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      sync1_q      <= pwm_in;
      pwm_s_q      <= sync1_q;
      pwm_d_q      <= pwm_s_q;
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      per_cnt_q    <= per_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      period_err_q <= period_err_d;
      full_on_q    <= full_on_d;
      locked_q     <= locked_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign period_err = period_err_q;
  assign full_on    = full_on_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: scoreboard bench for pwm_duty_decoder.
// Drives PWM periods, queues expected reports, compares them as they appear.
module tb_pwm_duty_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [3:0] duty;
  logic       duty_valid, period_err, full_on, locked;
  logic [3:0] duty_b;
  logic       duty_valid_b, period_err_b, full_on_b, locked_b;

  pwm_duty_decoder #(.PERIOD(16), .TOL(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty), .duty_valid(duty_valid), .period_err(period_err),
    .full_on(full_on), .locked(locked)
  );

  pwm_duty_decoder #(.PERIOD(16), .TOL(4), .CNT_W(8)) dut_tol (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty_b), .duty_valid(duty_valid_b), .period_err(period_err_b),
    .full_on(full_on_b), .locked(locked_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [3:0] duty;
    bit         full;
  } exp_t;

  exp_t       sb[$];
  int         vcyc[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         b_valid  = 0;
  int         b_err    = 0;
  int         rise_cyc = 0;
  bit         have_prev = 0;
  int         prev_hi  = 0;
  int         prev_per = 0;
  logic [3:0] held     = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (duty_valid_b) b_valid = b_valid + 1;
    if (period_err_b) b_err = b_err + 1;
    if (!rst && (duty_valid || period_err)) begin
      if (duty_valid) vcyc.push_back(cyc);
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_report: valid=%0b err=%0b duty=%0d, queue empty",
                 duty_valid, period_err, duty);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({period_err, duty_valid, duty, locked, full_on} !==
            {e.err, !e.err, e.duty, !e.err, e.full}) begin
          n_fail = n_fail + 1;
          $display("FAIL report: err/valid/duty/locked/full got %0b/%0b/%0d/%0b/%0b want %0b/%0b/%0d/%0b/%0b",
                   period_err, duty_valid, duty, locked, full_on,
                   e.err, !e.err, e.duty, !e.err, e.full);
        end
      end
    end
  end

  // Model: a rise closes the previous full period, if one was being measured.
  task automatic push_close();
    if (have_prev) begin
      if (prev_per == 16) begin
        held = (prev_hi > 15) ? 4'd15 : 4'(prev_hi);
        sb.push_back('{1'b0, held, 1'b0});
      end else begin
        sb.push_back('{1'b1, held, 1'b0});
      end
    end
  endtask

  task automatic drive_period(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      if (i == 0) begin
        push_close();
        rise_cyc = cyc;
      end
      pwm_in = (i < hi);
    end
    have_prev = 1;
    prev_hi   = hi;
    prev_per  = per;
  endtask

  task automatic wait_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = 1'b0;
    end
    prev_per = prev_per + n;
  endtask

  task automatic idle(input bit lvl, input int n, input bit to);
    if (to) begin
      held = lvl ? 4'd15 : 4'd0;
      sb.push_back('{1'b0, held, lvl});
      have_prev = 0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = lvl;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks = n_checks + 1;
    if ({duty, duty_valid, period_err, full_on, locked} !== 8'h00) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_hold: outputs=%h want 00",
               {duty, duty_valid, period_err, full_on, locked});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks = n_checks + 1;
    if ({duty, duty_valid, period_err, full_on, locked} !== 8'h00) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_release: outputs=%h want 00",
               {duty, duty_valid, period_err, full_on, locked});
    end
  endtask

  task automatic test_duty5();
    int rise2;
    vcyc.delete();
    drive_period(5, 16);
    drive_period(5, 16);
    rise2 = rise_cyc;
    repeat (3) drive_period(5, 16);
    wait_low(4);
    n_checks = n_checks + 1;
    if (vcyc.size() != 4) begin
      n_fail = n_fail + 1;
      $display("FAIL duty5_count: got %0d reports want 4", vcyc.size());
    end else begin
      n_checks = n_checks + 1;
      if (vcyc[0] - rise2 != 3) begin
        n_fail = n_fail + 1;
        $display("FAIL duty5_latency: got %0d cycles want 3", vcyc[0] - rise2);
      end
      n_checks = n_checks + 1;
      if (vcyc[3] - vcyc[0] != 48) begin
        n_fail = n_fail + 1;
        $display("FAIL duty5_spacing: got %0d cycles want 48", vcyc[3] - vcyc[0]);
      end
    end
    n_checks = n_checks + 1;
    if (locked !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL duty5_locked: got %b want 1", locked);
    end
  endtask

  task automatic test_sweep();
    for (int d = 1; d <= 15; d++) begin
      repeat (12) drive_period(d, 16);
      n_checks = n_checks + 1;
      if (duty !== 4'(d) || locked !== 1'b1) begin
        n_fail = n_fail + 1;
        $display("FAIL sweep_%0d: duty=%0d locked=%b want duty=%0d locked=1",
                 d, duty, locked, d);
      end
    end
  endtask

  task automatic test_timeout();
    idle(1'b0, 40, 1'b1);
    n_checks = n_checks + 1;
    if ({duty, full_on, locked} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail = n_fail + 1;
      $display("FAIL timeout_low: duty=%0d full=%b locked=%b want 0/0/1",
               duty, full_on, locked);
    end
    idle(1'b1, 40, 1'b1);
    n_checks = n_checks + 1;
    if ({duty, full_on, locked} !== {4'd15, 1'b1, 1'b1}) begin
      n_fail = n_fail + 1;
      $display("FAIL timeout_high: duty=%0d full=%b locked=%b want 15/1/1",
               duty, full_on, locked);
    end
    idle(1'b0, 4, 1'b0);
    drive_period(7, 16);
    drive_period(7, 16);
    n_checks = n_checks + 1;
    if ({duty, full_on, locked} !== {4'd7, 1'b0, 1'b1}) begin
      n_fail = n_fail + 1;
      $display("FAIL full_on_clear: duty=%0d full=%b locked=%b want 7/0/1",
               duty, full_on, locked);
    end
  endtask

  task automatic test_period_err();
    int bv0, be0;
    bv0 = b_valid;
    be0 = b_err;
    repeat (4) drive_period(5, 20);
    wait_low(4);
    n_checks = n_checks + 1;
    if (duty !== 4'd7 || locked !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL perr_hold: duty=%0d locked=%b want 7/0", duty, locked);
    end
    n_checks = n_checks + 1;
    if (b_valid - bv0 != 4 || b_err != be0) begin
      n_fail = n_fail + 1;
      $display("FAIL tol4_counts: valid=%0d err=%0d want 4/0",
               b_valid - bv0, b_err - be0);
    end
    n_checks = n_checks + 1;
    if (duty_b !== 4'd5 || locked_b !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL tol4_duty: duty=%0d locked=%b want 5/1", duty_b, locked_b);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) drive_period(9, 16);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) push_close();
      pwm_in = 1'b1;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks = n_checks + 1;
    if ({duty, duty_valid, period_err, full_on, locked} !== 8'h00) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid: outputs=%h want 00",
               {duty, duty_valid, period_err, full_on, locked});
    end
    have_prev = 0;
    held      = 4'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pwm_in = 1'b0;
      if (i == 3) rst = 1'b0;
    end
    n_checks = n_checks + 1;
    if (locked !== 1'b0 || duty !== 4'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_quiet: duty=%0d locked=%b want 0/0", duty, locked);
    end
    drive_period(9, 16);
    n_checks = n_checks + 1;
    if (locked !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_partial: locked=%b want 0", locked);
    end
    drive_period(9, 16);
    n_checks = n_checks + 1;
    if (duty !== 4'd9 || locked !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_relock: duty=%0d locked=%b want 9/1", duty, locked);
    end
  endtask

  task automatic test_glitch();
    drive_period(4, 5);
    drive_period(3, 11);
    drive_period(8, 16);
    n_checks = n_checks + 1;
    if (duty !== 4'd9 || locked !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL glitch_err: duty=%0d locked=%b want 9/0", duty, locked);
    end
    drive_period(8, 16);
    drive_period(8, 16);
    n_checks = n_checks + 1;
    if (duty !== 4'd8 || locked !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL glitch_relock: duty=%0d locked=%b want 8/1", duty, locked);
    end
    idle(1'b0, 40, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_duty5();
    test_sweep();
    test_timeout();
    test_period_err();
    test_reset_mid();
    test_glitch();
    repeat (5) @(negedge clk);
    n_checks = n_checks + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL missing_reports: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
